// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_MERGE,
      ST_WR,
      ST_LDRESP,
      ST_DONE
   } state_t;

   // Bit positions inside the one-hot size field {byte, half, word}.
   localparam int unsigned SZ_BYTE = 2;
   localparam int unsigned SZ_HALF = 1;
   localparam int unsigned SZ_WORD = 0;

   localparam logic [31:0] DEFAULT_BASE = 32'h10010000;

endpackage

// File: rtl/dmem_if.sv
// CPU data-port bundle: request fields in, completion/result out.
interface dmem_if;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [2:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   modport master (
      output req, we, addr, size, wdata,
      input  rdata, ready, err
   );

   modport slave (
      input  req, we, addr, size, wdata,
      output rdata, ready, err
   );

endinterface

// File: rtl/dmem_lane.sv
// Little-endian lane logic: sub-word extraction for loads and merge for stores.
module dmem_lane (
   input  logic [31:0] word,
   input  logic [15:0] data,
   input  logic [1:0]  lane,
   input  logic        byte_sel,
   input  logic        half_sel,
   output logic [31:0] ext,
   output logic [31:0] merged
);

   always_comb begin
      ext    = word;
      merged = word;
      if (byte_sel) begin
         ext                          = {24'h000000, word[{lane, 3'b000} +: 8]};
         merged[{lane, 3'b000} +: 8]  = data[7:0];
      end else if (half_sel) begin
         ext                          = {16'h0000, word[{lane[1], 4'b0000} +: 16]};
         merged[{lane[1], 4'b0000} +: 16] = data;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle controller between the CPU data port and a registered-read SRAM.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE   = DEFAULT_BASE,
   parameter int unsigned MEM_AW = 11
) (
   input  logic              clk,
   input  logic              rst,
   dmem_if.slave             bus,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned OFF_W     = MEM_AW + 2;
   localparam logic [31:0] MEM_BYTES = 32'd4 << MEM_AW;

   state_t           state, state_nx;
   logic [OFF_W-1:0] off_q;
   logic             we_q, bad_q, byte_q, half_q;
   logic [31:0]      wdata_q, rdata_q;
   logic [31:0]      off;
   logic             bad;
   logic [31:0]      lane_ext, lane_merged;

   assign off = bus.addr - BASE;

   always_comb begin
      bad = (off >= MEM_BYTES)
         || !$onehot(bus.size)
         || (bus.size[SZ_HALF] && off[0])
         || (bus.size[SZ_WORD] && (off[1:0] != 2'b00));
   end

   dmem_lane u_lane (
      .word     (mem_rdata),
      .data     (wdata_q[15:0]),
      .lane     (off_q[1:0]),
      .byte_sel (byte_q),
      .half_sel (half_q),
      .ext      (lane_ext),
      .merged   (lane_merged)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         off_q   <= '0;
         we_q    <= 1'b0;
         bad_q   <= 1'b0;
         byte_q  <= 1'b0;
         half_q  <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && bus.req) begin
            off_q   <= off[OFF_W-1:0];
            we_q    <= bus.we;
            bad_q   <= bad;
            byte_q  <= bus.size[SZ_BYTE];
            half_q  <= bus.size[SZ_HALF];
            wdata_q <= bus.wdata;
            rdata_q <= '0;
         end
         if (state == ST_LDRESP) begin
            rdata_q <= lane_ext;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (bus.req) begin
               if (bad)                                 state_nx = ST_DONE;
               else if (bus.we && bus.size[SZ_WORD])    state_nx = ST_WR;
               else                                     state_nx = ST_RD;
            end
         end
         ST_RD:     state_nx = we_q ? ST_MERGE : ST_LDRESP;
         ST_MERGE:  state_nx = ST_DONE;
         ST_WR:     state_nx = ST_DONE;
         ST_LDRESP: state_nx = ST_DONE;
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // SRAM strobes come from state alone, so async reset drops them immediately.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         ST_RD: begin
            mem_en = 1'b1;
         end
         ST_MERGE: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = lane_merged;
         end
         ST_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
         end
         default: ;
      endcase
   end

   assign mem_addr  = off_q[OFF_W-1:2];
   assign bus.ready = (state == ST_DONE);
   assign bus.err   = (state == ST_DONE) && bad_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a registered-read SRAM model.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_en, mem_we;
   logic [10:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   dmem_if bus();

   dmem_ctrl #(.BASE(32'h10010000), .MEM_AW(11)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   logic [31:0] mem [0:2047];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   int unsigned cyc = 0;
   int unsigned we_cnt = 0;
   logic [31:0] last_wr_addr = '0;
   always @(posedge clk) begin
      cyc++;
      if (mem_en && mem_we) begin
         we_cnt++;
         last_wr_addr = {21'b0, mem_addr};
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned cyc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int unsigned ready_cyc_last = 0;
   int unsigned ready_cyc_prev = 0;

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && bus.ready) begin
         ready_cyc_prev = ready_cyc_last;
         ready_cyc_last = cyc;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got ready=1 expected no response");
         end else begin
            e = sb.pop_front();
            chk32({e.name, "_rdata"}, bus.rdata, e.rdata);
            chk32({e.name, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
            chk32({e.name, "_cycle"}, cyc, e.cyc);
         end
      end
   end

   // start_now: fields are driven on the current negedge (used at a ready pulse);
   // hold: leave req asserted after completion for back-to-back issue.
   task automatic do_req(input string name, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int unsigned lat, input bit start_now, input bit hold);
      exp_t        e;
      int unsigned base_cyc;
      bit          seen = 1'b0;
      if (!start_now) @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = a;
      bus.size  = s;
      bus.wdata = wd;
      base_cyc  = start_now ? cyc + 1 : cyc;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = base_cyc + lat;
      e.name  = name;
      sb.push_back(e);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (!hold) bus.req = 1'b0;
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no ready expected ready within 20 cycles", name);
         void'(sb.pop_back());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned wc;
      bit          seen;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = '0;
      bus.size  = 3'b001;
      bus.wdata = '0;

      #2;
      chk32("rst_ready",     {31'b0, bus.ready}, 32'd0);
      chk32("rst_err",       {31'b0, bus.err},   32'd0);
      chk32("rst_mem_en",    {31'b0, mem_en},    32'd0);
      chk32("rst_mem_we",    {31'b0, mem_we},    32'd0);
      chk32("rst_rdata",     bus.rdata,          32'd0);
      chk32("rst_mem_addr",  {21'b0, mem_addr},  32'd0);
      chk32("rst_mem_wdata", mem_wdata,          32'd0);
      @(negedge clk);
      rst = 1'b1;

      // word store then load
      do_req("st_w", 1'b1, 32'h10010008, 3'b001, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0, 1'b0);
      chk32("st_w_addr", last_wr_addr, 32'd2);
      chk32("st_w_mem", mem[2], 32'hDEADBEEF);
      do_req("ld_w", 1'b0, 32'h10010008, 3'b001, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0, 1'b0);

      // byte merge
      do_req("st_w2", 1'b1, 32'h10010008, 3'b001, 32'h11223344, 32'h0, 1'b0, 2, 1'b0, 1'b0);
      do_req("st_b", 1'b1, 32'h1001000A, 3'b100, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 1'b0, 1'b0);
      chk32("st_b_mem", mem[2], 32'h11AB3344);
      do_req("ld_b", 1'b0, 32'h1001000A, 3'b100, 32'h0, 32'h000000AB, 1'b0, 3, 1'b0, 1'b0);
      do_req("ld_b0", 1'b0, 32'h10010008, 3'b100, 32'h0, 32'h00000044, 1'b0, 3, 1'b0, 1'b0);

      // half accesses
      do_req("st_w3", 1'b1, 32'h1001000C, 3'b001, 32'h55667788, 32'h0, 1'b0, 2, 1'b0, 1'b0);
      do_req("st_h", 1'b1, 32'h1001000E, 3'b010, 32'h0000CAFE, 32'h0, 1'b0, 3, 1'b0, 1'b0);
      chk32("st_h_mem", mem[3], 32'hCAFE7788);
      do_req("ld_h", 1'b0, 32'h1001000E, 3'b010, 32'h0, 32'h0000CAFE, 1'b0, 3, 1'b0, 1'b0);
      do_req("ld_hlo", 1'b0, 32'h1001000C, 3'b010, 32'h0, 32'h00007788, 1'b0, 3, 1'b0, 1'b0);

      // rejected requests
      wc = we_cnt;
      do_req("e_half", 1'b0, 32'h10010001, 3'b010, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0);
      do_req("e_word", 1'b1, 32'h10010002, 3'b001, 32'h12345678, 32'h0, 1'b1, 1, 1'b0, 1'b0);
      do_req("e_range", 1'b1, 32'h10018000, 3'b100, 32'h000000EE, 32'h0, 1'b1, 1, 1'b0, 1'b0);
      do_req("e_size", 1'b0, 32'h10010008, 3'b011, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0);
      chk32("err_no_write", we_cnt, wc);
      chk32("err_mem2", mem[2], 32'h11AB3344);

      // reset during MERGE
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 32'h10010009;
      bus.size  = 3'b100;
      bus.wdata = 32'h00000077;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_we) begin
            seen = 1'b1;
            break;
         end
      end
      chk32("rm_reached_merge", {31'b0, seen}, 32'd1);
      bus.req = 1'b0;
      rst = 1'b0;
      #1;
      chk32("rm_mem_en",    {31'b0, mem_en},    32'd0);
      chk32("rm_mem_we",    {31'b0, mem_we},    32'd0);
      chk32("rm_ready",     {31'b0, bus.ready}, 32'd0);
      chk32("rm_mem_addr",  {21'b0, mem_addr},  32'd0);
      chk32("rm_mem_wdata", mem_wdata,          32'd0);
      chk32("rm_rdata",     bus.rdata,          32'd0);
      @(posedge clk);
      #1;
      chk32("rm_mem_kept", mem[2], 32'h11AB3344);
      @(negedge clk);
      rst = 1'b1;
      do_req("rm_ld", 1'b0, 32'h10010008, 3'b001, 32'h0, 32'h11AB3344, 1'b0, 3, 1'b0, 1'b0);

      // back-to-back with req held
      do_req("b2b_1", 1'b0, 32'h10010008, 3'b001, 32'h0, 32'h11AB3344, 1'b0, 3, 1'b0, 1'b1);
      do_req("b2b_2", 1'b0, 32'h1001000C, 3'b001, 32'h0, 32'hCAFE7788, 1'b0, 3, 1'b1, 1'b0);
      @(negedge clk);
      chk32("b2b_gap", ready_cyc_last - ready_cyc_prev, 32'd4);

      repeat (3) @(negedge clk);
      chk32("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
